cabac_bit_buffer: RTL and testbench

Bitstream front end of the VVC arithmetic decoder. Consumes the byte stream from the file/byte source over a request/ready handshake and strips H.266 emulation-prevention bytes (00 00 03). Buffers the payload bits MSB-first and serves 0–16-bit reads to the arithmetic decoding engine (range/offset init and renormalisation).

---
 rtl/cabac_bit_buffer_if.sv | 41 ++++
 rtl/cabac_bit_buffer.sv | 128 ++++++++++++
 tb/tb_cabac_bit_buffer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cabac_bit_buffer_if.sv
// Byte-source and bit-read handshake bundle for cabac_bit_buffer.
// master: byte source + arithmetic engine side; slave: the bit buffer.
//   byte_in/byte_valid/byte_req : byte stream, accepted on byte_req && byte_valid
//   rd_en/rd_len                : read request, 0..16 bits, held until rd_valid
//   rd_data/rd_valid            : right-aligned read result, one-cycle pulse
//   bits_avail/eos              : buffered bit count, end-of-stream flag
interface cabac_bit_buffer_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_req;
    logic        rd_en;
    logic [4:0]  rd_len;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [5:0]  bits_avail;
    logic        eos;

    modport master (
        output byte_in,
        output byte_valid,
        output rd_en,
        output rd_len,
        input  byte_req,
        input  rd_data,
        input  rd_valid,
        input  bits_avail,
        input  eos
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        input  rd_en,
        input  rd_len,
        output byte_req,
        output rd_data,
        output rd_valid,
        output bits_avail,
        output eos
    );
endinterface

// File: rtl/cabac_bit_buffer.sv
// VVC CABAC bitstream front end: strips 00 00 03 emulation-prevention
// bytes and serves MSB-first 0..16-bit reads to the arithmetic decoder.
// Ports:
//   clk  : single clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : cabac_bit_buffer_if.slave (byte source + read port)
// Parameters:
//   BUF_W      : buffer capacity in bits (multiple of 8, >= 24)
//   EPB_REMOVE : 1 drops emulation-prevention 0x03 bytes
module cabac_bit_buffer #(
    parameter int BUF_W      = 32,
    parameter bit EPB_REMOVE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    cabac_bit_buffer_if.slave bus
);

    localparam int CW = $clog2(BUF_W + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t FILL_MAX = cnt_t'(BUF_W - 8);
    localparam cnt_t BYTE_W   = cnt_t'(8);

    // Buffer is left-aligned: the next bit to read is buf_q[BUF_W-1],
    // and every bit below position BUF_W-1-count is kept at zero so a
    // new byte can simply be OR-ed in.
    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_d;
    logic [BUF_W-1:0] buf_sh;
    logic [BUF_W-1:0] byte_pos;
    cnt_t             count_q;
    cnt_t             count_d;
    cnt_t             count_sh;
    logic [1:0]       zero_run_q;
    logic [1:0]       zero_run_d;
    logic [15:0]      rd_data_q;
    logic [15:0]      rd_data_d;
    logic             rd_valid_q;
    logic             eos_q;
    logic             eos_d;

    logic [4:0]       eff_len;
    logic             byte_req;
    logic             byte_acc;
    logic             byte_zero;
    logic             epb_hit;
    logic             append;
    logic             rd_acc;

    // Lengths above 16 are clamped rather than rejected.
    assign eff_len = (bus.rd_len > 5'd16) ? 5'd16 : bus.rd_len;

    // Request only while a whole byte fits, so an append never depends
    // on a read happening in the same cycle.
    assign byte_req  = !rst && (count_q <= FILL_MAX);
    assign byte_acc  = byte_req && bus.byte_valid;
    assign byte_zero = (bus.byte_in == 8'h00);

    assign epb_hit = EPB_REMOVE
                   && (zero_run_q == 2'd2)
                   && (bus.byte_in == 8'h03);

    assign append = byte_acc && !epb_hit;

    // A short read simply waits; it completes once bytes arrive.
    assign rd_acc = bus.rd_en && (cnt_t'(eff_len) <= count_q);

    always_comb begin
        buf_sh    = buf_q;
        count_sh  = count_q;
        rd_data_d = rd_data_q;

        if (rd_acc) begin
            buf_sh    = buf_q << eff_len;
            count_sh  = count_q - cnt_t'(eff_len);
            // Shift by 16 for a zero-length read yields 0.
            rd_data_d = buf_q[BUF_W-1 -: 16] >> (5'd16 - eff_len);
        end

        // The byte lands right after the bits that survive the read.
        byte_pos = {bus.byte_in, {(BUF_W-8){1'b0}}} >> count_sh;

        buf_d   = buf_sh;
        count_d = count_sh;
        if (append) begin
            buf_d   = buf_sh | byte_pos;
            count_d = count_sh + BYTE_W;
        end

        zero_run_d = zero_run_q;
        if (byte_acc) begin
            if (!byte_zero) begin
                zero_run_d = 2'd0;
            end else if (zero_run_q != 2'd2) begin
                zero_run_d = zero_run_q + 2'd1;
            end
        end

        eos_d = (count_d == '0) && !bus.byte_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q      <= '0;
            count_q    <= '0;
            zero_run_q <= 2'd0;
            rd_data_q  <= 16'd0;
            rd_valid_q <= 1'b0;
            eos_q      <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            count_q    <= count_d;
            zero_run_q <= zero_run_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_acc;
            eos_q      <= eos_d;
        end
    end

    assign bus.byte_req   = byte_req;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.bits_avail = 6'(count_q);
    assign bus.eos        = eos_q;

endmodule

// File: tb/tb_cabac_bit_buffer.sv
// Testbench for cabac_bit_buffer: directed scenarios plus random
// traffic against a bit-FIFO reference model, EPB on and off.
module tb_cabac_bit_buffer;

    localparam int BUF_W = 32;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_v;

    always #5 clk = ~clk;

    cabac_bit_buffer_if b0 ();
    cabac_bit_buffer_if b1 ();

    cabac_bit_buffer #(.BUF_W(BUF_W), .EPB_REMOVE(1'b0)) u_dut0 (
        .clk (clk),
        .rst (rst_v),
        .bus (b0)
    );

    cabac_bit_buffer #(.BUF_W(BUF_W), .EPB_REMOVE(1'b1)) u_dut1 (
        .clk (clk),
        .rst (rst_v),
        .bus (b1)
    );

    logic        bv[2];
    logic [7:0]  bi[2];
    logic        rdn[2];
    logic [4:0]  rl[2];

    logic [63:0] mval[2];
    int          mcnt[2];
    int          mzr[2];

    logic        s_rv[2];
    logic [15:0] s_rd[2];
    logic        s_req[2];
    logic [5:0]  s_ba[2];
    logic        s_eos[2];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [15:0] ed[2];
        logic        ev[2];
        logic        ee[2];
        logic        racc;
        logic        acc;
        logic        drop;
        int          eff;
        b0.byte_in = bi[0]; b0.byte_valid = bv[0];
        b0.rd_en = rdn[0];  b0.rd_len = rl[0];
        b1.byte_in = bi[1]; b1.byte_valid = bv[1];
        b1.rd_en = rdn[1];  b1.rd_len = rl[1];
        for (int k = 0; k < 2; k++) begin
            ed[k] = 16'd0; ev[k] = 1'b0; ee[k] = 1'b0;
            eff = (rl[k] > 5'd16) ? 16 : int'(rl[k]);
            if (rst_v) begin
                mcnt[k] = 0; mval[k] = 64'd0; mzr[k] = 0;
            end else begin
                racc = rdn[k] && (eff <= mcnt[k]);
                acc  = bv[k] && (mcnt[k] <= BUF_W - 8);
                if (racc) begin
                    ed[k] = 16'((mval[k] >> (mcnt[k] - eff))
                                & ((64'd1 << eff) - 64'd1));
                    mcnt[k] = mcnt[k] - eff;
                    mval[k] = mval[k] & ((64'd1 << mcnt[k]) - 64'd1);
                end
                if (acc) begin
                    drop = (k == 1) && (mzr[k] == 2) && (bi[k] == 8'h03);
                    if (bi[k] == 8'h00) mzr[k] = (mzr[k] < 2) ? mzr[k] + 1 : 2;
                    else mzr[k] = 0;
                    if (!drop) begin
                        mval[k] = (mval[k] << 8) | 64'(bi[k]);
                        mcnt[k] = mcnt[k] + 8;
                    end
                end
                ev[k] = racc;
                ee[k] = (mcnt[k] == 0) && !bv[k];
            end
        end
        @(posedge clk);
        #1;
        s_rv[0] = b0.rd_valid; s_rd[0] = b0.rd_data; s_req[0] = b0.byte_req;
        s_ba[0] = b0.bits_avail; s_eos[0] = b0.eos;
        s_rv[1] = b1.rd_valid; s_rd[1] = b1.rd_data; s_req[1] = b1.byte_req;
        s_ba[1] = b1.bits_avail; s_eos[1] = b1.eos;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d rd_valid", k), s_rv[k], ev[k]);
            chk($sformatf("d%0d bits_avail", k), s_ba[k], mcnt[k]);
            chk($sformatf("d%0d eos", k), s_eos[k], ee[k]);
            chk($sformatf("d%0d byte_req", k), s_req[k],
                rst_v ? 1'b0 : (mcnt[k] <= BUF_W - 8));
            if (ev[k]) chk($sformatf("d%0d rd_data", k), s_rd[k], ed[k]);
            if (rst_v) chk($sformatf("d%0d rst_rd_data", k), s_rd[k], 16'd0);
        end
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            bv[k] = 1'b0; bi[k] = 8'h00; rdn[k] = 1'b0; rl[k] = 5'd0;
        end
    endtask

    task automatic do_reset();
        idle();
        rst_v = 1'b1;
        tick();
        tick();
        rst_v = 1'b0;
        tick();
    endtask

    task automatic push(int k, logic [7:0] b);
        logic ok;
        ok = 1'b0;
        bi[k] = b;
        bv[k] = 1'b1;
        for (int n = 0; n < 40 && !ok; n++) begin
            ok = s_req[k];
            tick();
        end
        bv[k] = 1'b0;
        if (!ok) chk($sformatf("d%0d push_timeout", k), ok, 1'b1);
    endtask

    task automatic rd(int k, int len, output logic [15:0] d);
        logic ok;
        ok = 1'b0;
        rdn[k] = 1'b1;
        rl[k] = 5'(len);
        for (int n = 0; n < 40 && !ok; n++) begin
            tick();
            ok = s_rv[k];
        end
        rdn[k] = 1'b0;
        d = s_rd[k];
        if (!ok) chk($sformatf("d%0d rd_timeout", k), ok, 1'b1);
    endtask

    task automatic stream(int k, input bq_t s, output bq_t r);
        logic [15:0] d;
        r = {};
        foreach (s[i]) begin
            push(k, s[i]);
            for (int n = 0; n < 8 && s_ba[k] >= 6'd8; n++) begin
                rd(k, 8, d);
                r.push_back(d[7:0]);
            end
        end
    endtask

    task automatic cmp_q(string tag, bq_t got, bq_t exp);
        chk({tag, "_len"}, got.size(), exp.size());
        foreach (exp[i]) begin
            if (i < got.size()) chk($sformatf("%s_%0d", tag, i), got[i], exp[i]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        logic        seen;
        int          n_acc;
        bq_t         res;

        for (int k = 0; k < 2; k++) begin
            s_req[k] = 1'b0; s_rv[k] = 1'b0; s_ba[k] = 6'd0;
            mcnt[k] = 0; mval[k] = 64'd0; mzr[k] = 0;
        end
        rst_v = 1'b1;
        idle();
        do_reset();

        // basic read
        push(1, 8'hA5);
        push(1, 8'h3C);
        rd(1, 4, d);
        chk("basic_r4", d, 16'h000A);
        rd(1, 12, d);
        chk("basic_r12", d, 16'h053C);
        chk("basic_ba", s_ba[1], 6'd0);
        rd(1, 0, d);
        chk("basic_r0", d, 16'h0000);

        // emulation prevention on / off
        do_reset();
        stream(1, '{8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h03, 8'h01}, res);
        cmp_q("epb1", res, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01});
        stream(0, '{8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h03, 8'h01}, res);
        cmp_q("epb0", res,
              '{8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h03, 8'h01});
        do_reset();
        stream(1, '{8'h00, 8'h00, 8'h03, 8'h03}, res);
        cmp_q("epbnm", res, '{8'h00, 8'h00, 8'h03});

        // fill to capacity
        do_reset();
        n_acc = 0;
        bv[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (s_req[1]) n_acc++;
            bi[1] = 8'h11 + 8'(i);
            tick();
        end
        bv[1] = 1'b0;
        chk("fill_acc", n_acc, 4);
        chk("fill_ba", s_ba[1], 6'd32);
        chk("fill_req", s_req[1], 1'b0);
        rd(1, 16, d);
        chk("fill_data", d, 16'h1112);
        chk("fill_req2", s_req[1], 1'b1);
        push(1, 8'h5A);
        chk("fill_ba2", s_ba[1], 6'd24);

        // stall with a short buffer
        do_reset();
        push(1, 8'hC7);
        rd(1, 4, d);
        rdn[1] = 1'b1;
        rl[1] = 5'd8;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | s_rv[1];
        end
        chk("stall_norv", seen, 1'b0);
        push(1, 8'h9E);
        chk("stall_early", s_rv[1], 1'b0);
        tick();
        rdn[1] = 1'b0;
        chk("stall_rv", s_rv[1], 1'b1);
        chk("stall_data", s_rd[1], 16'h0079);

        // read and append on the same edge
        do_reset();
        push(1, 8'hD2);
        push(1, 8'h4B);
        push(1, 8'h96);
        bi[1] = 8'hE1; bv[1] = 1'b1;
        rdn[1] = 1'b1; rl[1] = 5'd16;
        tick();
        bv[1] = 1'b0; rdn[1] = 1'b0;
        chk("cc_rv", s_rv[1], 1'b1);
        chk("cc_data", s_rd[1], 16'hD24B);
        chk("cc_ba", s_ba[1], 6'd16);
        rd(1, 16, d);
        chk("cc_tail", d, 16'h96E1);

        // mid-stream reset with a pending read
        do_reset();
        push(1, 8'h01);
        push(1, 8'h02);
        push(1, 8'h03);
        rd(1, 4, d);
        chk("rst_pre_ba", s_ba[1], 6'd20);
        rst_v = 1'b1;
        rdn[1] = 1'b1; rl[1] = 5'd16;
        tick();
        chk("rst_ba", s_ba[1], 6'd0);
        chk("rst_rv", s_rv[1], 1'b0);
        chk("rst_req", s_req[1], 1'b0);
        rst_v = 1'b0;
        rdn[1] = 1'b0;
        tick();
        chk("rst_req2", s_req[1], 1'b1);
        chk("rst_ba2", s_ba[1], 6'd0);

        // drain to end of stream
        do_reset();
        push(1, 8'h12);
        push(1, 8'h34);
        chk("eos_pre", s_eos[1], 1'b0);
        rd(1, 16, d);
        chk("eos_data", d, 16'h1234);
        chk("eos_set", s_eos[1], 1'b1);

        // random traffic on both instances
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!(rdn[k] && !s_rv[k]) || c == 0) begin
                    rdn[k] = 1'($urandom_range(0, 1));
                    rl[k] = 5'($urandom_range(0, 20));
                end
                bv[k] = ($urandom_range(0, 9) < 6);
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: bi[k] = 8'h00;
                    4, 5:       bi[k] = 8'h03;
                    default:    bi[k] = 8'($urandom);
                endcase
            end
            rst_v = ($urandom_range(0, 499) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                if (s_rv[k]) rdn[k] = 1'b0;
            end
        end
        rst_v = 1'b0;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
